// File: rtl/power_accum_pkg.sv
// Shared types and default widths for the power accumulator.
package power_accum_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DUMP
  } state_t;

  localparam int LANES = 4;

  localparam int DEF_DATA_WIDTH      = 53;
  localparam int DEF_ACC_WIDTH       = 64;
  localparam int DEF_INDEX_WIDTH     = 11;
  localparam int DEF_NUM_COLS        = 2048;
  localparam int DEF_FRAME_CNT_WIDTH = 8;

  typedef logic [LANES-1:0][DEF_DATA_WIDTH-1:0] dataLanes_t;
  typedef logic [LANES-1:0][DEF_ACC_WIDTH-1:0]  accLanes_t;

endpackage

// File: rtl/sat_add_lanes.sv
// Four-lane unsigned adder that clamps each lane to all-ones on carry-out.
module sat_add_lanes
  import power_accum_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH
) (
  input  logic [LANES-1:0][ACC_WIDTH-1:0]  i_base,
  input  logic [LANES-1:0][DATA_WIDTH-1:0] i_addend,
  output logic [LANES-1:0][ACC_WIDTH-1:0]  o_sum,
  output logic                             o_sat
);

  localparam int SUM_W = ACC_WIDTH + 1;

  logic [LANES-1:0][ACC_WIDTH:0] w_full;

  always_comb begin
    w_full = '0;
    o_sum  = '0;
    o_sat  = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      w_full[l] = {1'b0, i_base[l]} + SUM_W'(i_addend[l]);
      if (w_full[l][ACC_WIDTH]) begin
        o_sum[l] = '1;
        o_sat    = 1'b1;
      end else begin
        o_sum[l] = w_full[l][ACC_WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/power_accum.sv
// Integrates 4-lane column power over N frames, then streams the array out
// in column order over a valid/ready interface.
module power_accum
  import power_accum_pkg::*;
#(
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH       = DEF_ACC_WIDTH,
  parameter int INDEX_WIDTH     = DEF_INDEX_WIDTH,
  parameter int NUM_COLS        = DEF_NUM_COLS,
  parameter int FRAME_CNT_WIDTH = DEF_FRAME_CNT_WIDTH
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [FRAME_CNT_WIDTH-1:0]        num_frames,
  input  logic                              in_valid,
  input  logic                              in_last,
  input  logic [LANES-1:0][DATA_WIDTH-1:0]  in_col_1,
  input  logic [LANES-1:0][DATA_WIDTH-1:0]  in_col_2,
  input  logic [INDEX_WIDTH-1:0]            in_index_col1,
  input  logic [INDEX_WIDTH-1:0]            in_index_col2,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [INDEX_WIDTH-1:0]            out_index,
  output logic [LANES-1:0][ACC_WIDTH-1:0]   out_data,
  output logic                              busy,
  output logic                              done,
  output logic                              drop_err,
  output logic                              sat_err
);

  localparam int COL_W  = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam int DUMP_W = $clog2(NUM_COLS + 1);

  typedef logic [LANES-1:0][ACC_WIDTH-1:0] accRow_t;

  state_t                     r_state;
  logic [FRAME_CNT_WIDTH-1:0] r_numFrames;
  logic [FRAME_CNT_WIDTH-1:0] r_frameCnt;
  logic [DUMP_W-1:0]          r_dumpIdx;
  accRow_t                    r_acc [NUM_COLS];
  logic [NUM_COLS-1:0]        r_fresh;

  logic [COL_W-1:0] w_col1;
  logic [COL_W-1:0] w_col2;
  logic [COL_W-1:0] w_dumpCol;
  logic             w_accept;
  logic             w_inRange1;
  logic             w_inRange2;
  logic             w_use2;
  logic             w_act1;
  logic             w_act2;
  logic             w_same;
  logic             w_lastFrame;
  logic             w_loadOut;
  logic             w_moreCols;
  logic             w_sat1;
  logic             w_sat2;
  accRow_t          w_base1;
  accRow_t          w_base2;
  accRow_t          w_sum1;
  accRow_t          w_sum2;
  accRow_t          w_dumpData;

  assign w_col1     = in_index_col1[COL_W-1:0];
  assign w_col2     = in_index_col2[COL_W-1:0];
  assign w_accept   = in_valid && !rst && (r_state == ACCUM);
  assign w_inRange1 = 32'(in_index_col1) < 32'(NUM_COLS);
  assign w_inRange2 = 32'(in_index_col2) < 32'(NUM_COLS);
  assign w_use2     = in_index_col1 > INDEX_WIDTH'(1);
  assign w_act1     = w_accept && w_inRange1;
  assign w_act2     = w_accept && w_use2 && w_inRange2;
  assign w_same     = w_act1 && w_act2 && (in_index_col1 == in_index_col2);

  // A column not yet written in this run reads as zero, so the first frame
  // overwrites and nothing from an earlier run can leak into the sums.
  assign w_base1 = r_fresh[w_col1] ? r_acc[w_col1] : '0;
  assign w_base2 = w_same ? w_sum1 : (r_fresh[w_col2] ? r_acc[w_col2] : '0);

  sat_add_lanes #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_add1 (
    .i_base   (w_base1),
    .i_addend (in_col_1),
    .o_sum    (w_sum1),
    .o_sat    (w_sat1)
  );

  sat_add_lanes #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_add2 (
    .i_base   (w_base2),
    .i_addend (in_col_2),
    .o_sum    (w_sum2),
    .o_sat    (w_sat2)
  );

  assign w_lastFrame = (r_frameCnt == (r_numFrames - 1'b1));
  assign w_dumpCol   = r_dumpIdx[COL_W-1:0];
  assign w_dumpData  = r_fresh[w_dumpCol] ? r_acc[w_dumpCol] : '0;
  assign w_loadOut   = !out_valid || out_ready;
  assign w_moreCols  = r_dumpIdx < DUMP_W'(NUM_COLS);

  assign busy = (r_state != IDLE);

  // Array storage carries no reset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (w_act1 && !w_same) begin
      r_acc[w_col1] <= w_sum1;
    end
    if (w_act2) begin
      r_acc[w_col2] <= w_sum2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_numFrames <= '0;
      r_frameCnt  <= '0;
      r_dumpIdx   <= '0;
      r_fresh     <= '0;
      out_valid   <= 1'b0;
      out_index   <= '0;
      out_data    <= '0;
      done        <= 1'b0;
      drop_err    <= 1'b0;
      sat_err     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state     <= ACCUM;
            r_numFrames <= (num_frames == '0) ? FRAME_CNT_WIDTH'(1) : num_frames;
            r_frameCnt  <= '0;
            r_fresh     <= '0;
            drop_err    <= 1'b0;
            sat_err     <= 1'b0;
          end
        end
        ACCUM: begin
          if (w_act1 && !w_same) begin
            r_fresh[w_col1] <= 1'b1;
          end
          if (w_act2) begin
            r_fresh[w_col2] <= 1'b1;
          end
          if (w_accept && in_last) begin
            if (w_lastFrame) begin
              r_state   <= DUMP;
              r_dumpIdx <= '0;
            end else begin
              r_frameCnt <= r_frameCnt + 1'b1;
            end
          end
        end
        DUMP: begin
          // Reaching the end of the array with the last beat taken ends the run.
          if (w_loadOut) begin
            if (w_moreCols) begin
              out_valid <= 1'b1;
              out_index <= INDEX_WIDTH'(r_dumpIdx);
              out_data  <= w_dumpData;
              r_dumpIdx <= r_dumpIdx + 1'b1;
            end else begin
              out_valid <= 1'b0;
              done      <= 1'b1;
              r_state   <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
      if ((in_valid && (r_state != ACCUM)) ||
          (w_accept && !w_inRange1) ||
          (w_accept && w_use2 && !w_inRange2)) begin
        drop_err <= 1'b1;
      end
      if ((w_act1 && w_sat1) || (w_act2 && w_sat2)) begin
        sat_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_power_accum.sv
// Scoreboard bench for power_accum with an 8-column, narrow-lane configuration.
module tb_power_accum;
  import power_accum_pkg::*;

  localparam int DW = 16;
  localparam int AW = 17;
  localparam int IW = 4;
  localparam int NC = 8;
  localparam int FW = 8;
  localparam logic [AW-1:0] AMAX = '1;

  typedef logic [LANES-1:0][DW-1:0] dLanes_t;
  typedef logic [LANES-1:0][AW-1:0] aLanes_t;
  typedef struct {
    logic [IW-1:0] idx;
    aLanes_t       data;
  } beat_t;

  logic          clk;
  logic          rst;
  logic          start;
  logic [FW-1:0] num_frames;
  logic          in_valid;
  logic          in_last;
  dLanes_t       in_col_1;
  dLanes_t       in_col_2;
  logic [IW-1:0] in_index_col1;
  logic [IW-1:0] in_index_col2;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_index;
  aLanes_t       out_data;
  logic          busy;
  logic          done;
  logic          drop_err;
  logic          sat_err;

  power_accum #(
    .DATA_WIDTH      (DW),
    .ACC_WIDTH       (AW),
    .INDEX_WIDTH     (IW),
    .NUM_COLS        (NC),
    .FRAME_CNT_WIDTH (FW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .num_frames    (num_frames),
    .in_valid      (in_valid),
    .in_last       (in_last),
    .in_col_1      (in_col_1),
    .in_col_2      (in_col_2),
    .in_index_col1 (in_index_col1),
    .in_index_col2 (in_index_col2),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_index     (out_index),
    .out_data      (out_data),
    .busy          (busy),
    .done          (done),
    .drop_err      (drop_err),
    .sat_err       (sat_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int      testsRun;
  int      testsFailed;
  beat_t   expQ[$];
  beat_t   monExp;
  aLanes_t modelAcc [NC];
  bit      modelFresh [NC];
  bit      modelSat;

  function automatic dLanes_t allLanes(input logic [DW-1:0] v);
    dLanes_t r;
    for (int l = 0; l < LANES; l++) r[l] = v;
    return r;
  endfunction

  function automatic aLanes_t accLanes(input logic [AW-1:0] v);
    aLanes_t r;
    for (int l = 0; l < LANES; l++) r[l] = v;
    return r;
  endfunction

  task automatic modelAdd(input int idx, input dLanes_t v);
    longint s;
    if (idx >= NC) return;
    for (int l = 0; l < LANES; l++) begin
      s = (modelFresh[idx] ? longint'(modelAcc[idx][l]) : 0) + longint'(v[l]);
      if (s > longint'(AMAX)) begin
        s        = longint'(AMAX);
        modelSat = 1'b1;
      end
      modelAcc[idx][l] = AW'(s);
    end
    modelFresh[idx] = 1'b1;
  endtask

  task automatic modelClear();
    for (int c = 0; c < NC; c++) begin
      modelFresh[c] = 1'b0;
      modelAcc[c]   = '0;
    end
    modelSat = 1'b0;
  endtask

  task automatic pushModelDump();
    beat_t b;
    for (int c = 0; c < NC; c++) begin
      b.idx  = IW'(c);
      b.data = modelFresh[c] ? modelAcc[c] : '0;
      expQ.push_back(b);
    end
  endtask

  task automatic driveBeat(input int idx1, input int idx2, input dLanes_t c1,
                           input dLanes_t c2, input bit last);
    in_valid      = 1'b1;
    in_last       = last;
    in_index_col1 = IW'(idx1);
    in_index_col2 = IW'(idx2);
    in_col_1      = c1;
    in_col_2      = c2;
    modelAdd(idx1, c1);
    if (idx1 >= 2) modelAdd(idx2, c2);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic startRun(input int n);
    num_frames = FW'(n);
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    modelClear();
  endtask

  task automatic drainDump(output int doneSeen, output bit timedOut);
    out_ready = 1'b1;
    doneSeen  = 0;
    for (int i = 0; i < 100 && doneSeen == 0; i++) begin
      @(posedge clk); #1;
      if (done) doneSeen++;
    end
    timedOut = (doneSeen == 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (done) doneSeen++;
    end
    out_ready = 1'b0;
  endtask

  // Every accepted dump beat is matched against the head of the expected queue.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      testsRun++;
      if (expQ.size() == 0) begin
        testsFailed++;
        $display("[TB] FAIL dump_unexpected: got index %0d, required no beat", out_index);
      end else begin
        monExp = expQ.pop_front();
        if (out_index !== monExp.idx || out_data !== monExp.data) begin
          testsFailed++;
          $display("[TB] FAIL dump_beat: got index %0d data %h, required index %0d data %h",
                   out_index, out_data, monExp.idx, monExp.data);
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    testsRun++;
    if (out_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_out_valid: got %b required 0", out_valid); end
    testsRun++;
    if (out_index !== '0) begin testsFailed++; $display("[TB] FAIL reset_out_index: got %0d required 0", out_index); end
    testsRun++;
    if (out_data !== '0) begin testsFailed++; $display("[TB] FAIL reset_out_data: got %h required 0", out_data); end
    testsRun++;
    if ({busy, done, drop_err, sat_err} !== 4'b0000) begin
      testsFailed++;
      $display("[TB] FAIL reset_flags: got busy/done/drop/sat %b required 0000", {busy, done, drop_err, sat_err});
    end
    rst = 1'b0;
  endtask

  task automatic test_three_frames();
    beat_t   b;
    int      lat;
    int      doneSeen;
    bit      timedOut;
    int      expIdx [5] = '{0, 1, 1, 1, 2};
    bit      pat [4]    = '{1'b1, 1'b0, 1'b0, 1'b1};
    aLanes_t expD [5];
    expD[0] = accLanes(3);
    expD[1] = '0;
    expD[2] = '0;
    expD[3] = '0;
    expD[4] = accLanes(6);
    for (int c = 0; c < NC; c++) begin
      b.idx  = IW'(c);
      b.data = (c == 0) ? accLanes(3) : ((c >= 2 && c <= 5) ? accLanes(6) : '0);
      expQ.push_back(b);
    end
    out_ready = 1'b0;
    startRun(3);
    testsRun++;
    if (busy !== 1'b1) begin testsFailed++; $display("[TB] FAIL tf_busy: got %b required 1", busy); end
    for (int f = 0; f < 3; f++) begin
      driveBeat(0, 7, allLanes(1), allLanes(5), 1'b0);
      for (int k = 2; k <= 5; k++) driveBeat(k, 7 - k, allLanes(1), allLanes(1), k == 5);
    end
    lat = 0;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    testsRun++;
    if (lat !== 1) begin testsFailed++; $display("[TB] FAIL tf_dump_latency: got %0d cycles required 1", lat); end
    testsRun++;
    if (drop_err !== 1'b0) begin testsFailed++; $display("[TB] FAIL tf_drop_before: got %b required 0", drop_err); end
    for (int t = 0; t < 5; t++) begin
      testsRun++;
      if (out_valid !== 1'b1 || out_index !== IW'(expIdx[t]) || out_data !== expD[t]) begin
        testsFailed++;
        $display("[TB] FAIL tf_backpressure_%0d: got valid %b index %0d data %h, required valid 1 index %0d data %h",
                 t, out_valid, out_index, out_data, expIdx[t], expD[t]);
      end
      if (t < 4) begin
        out_ready = pat[t];
        if (t == 2) begin
          in_valid      = 1'b1;
          in_index_col1 = IW'(3);
          in_index_col2 = IW'(4);
          in_col_1      = allLanes(50);
          in_col_2      = allLanes(50);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
      end
    end
    testsRun++;
    if (drop_err !== 1'b1) begin testsFailed++; $display("[TB] FAIL tf_drop_in_dump: got %b required 1", drop_err); end
    drainDump(doneSeen, timedOut);
    testsRun++;
    if (timedOut || doneSeen !== 1) begin
      testsFailed++;
      $display("[TB] FAIL tf_done: got %0d pulses (timeout %b) required 1", doneSeen, timedOut);
    end
    testsRun++;
    if (expQ.size() !== 0 || busy !== 1'b0 || sat_err !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL tf_end: got %0d beats left busy %b sat %b, required 0 0 0", expQ.size(), busy, sat_err);
    end
  endtask

  task automatic test_same_index();
    beat_t b;
    int    doneSeen;
    bit    timedOut;
    startRun(0);
    testsRun++;
    if (drop_err !== 1'b0) begin testsFailed++; $display("[TB] FAIL si_drop_cleared: got %b required 0", drop_err); end
    driveBeat(4, 4, allLanes(2), allLanes(3), 1'b1);
    for (int c = 0; c < NC; c++) begin
      b.idx  = IW'(c);
      b.data = (c == 4) ? accLanes(5) : '0;
      expQ.push_back(b);
    end
    drainDump(doneSeen, timedOut);
    testsRun++;
    if (timedOut || doneSeen !== 1 || expQ.size() !== 0) begin
      testsFailed++;
      $display("[TB] FAIL si_done: got %0d pulses %0d beats left, required 1 and 0", doneSeen, expQ.size());
    end
  endtask

  task automatic test_saturation();
    dLanes_t ten;
    int      doneSeen;
    bit      timedOut;
    ten    = '0;
    ten[0] = DW'(10);
    startRun(1);
    driveBeat(2, 12, allLanes(7), allLanes(9), 1'b0);
    testsRun++;
    if (drop_err !== 1'b1) begin testsFailed++; $display("[TB] FAIL sat_range_drop: got %b required 1", drop_err); end
    driveBeat(6, 6, allLanes(16'hFFFF), allLanes(16'hFFFF), 1'b0);
    testsRun++;
    if (sat_err !== 1'b0) begin testsFailed++; $display("[TB] FAIL sat_near_max: got %b required 0", sat_err); end
    driveBeat(6, 3, ten, '0, 1'b1);
    testsRun++;
    if (sat_err !== 1'b1) begin testsFailed++; $display("[TB] FAIL sat_flag: got %b required 1", sat_err); end
    pushModelDump();
    drainDump(doneSeen, timedOut);
    testsRun++;
    if (timedOut || doneSeen !== 1 || expQ.size() !== 0) begin
      testsFailed++;
      $display("[TB] FAIL sat_done: got %0d pulses %0d beats left, required 1 and 0", doneSeen, expQ.size());
    end
  endtask

  task automatic test_reset_mid_accum();
    int doneSeen;
    bit timedOut;
    startRun(2);
    driveBeat(2, 5, allLanes(100), allLanes(100), 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    testsRun++;
    if ({out_valid, busy, done, drop_err, sat_err} !== 5'b0 || out_index !== '0 || out_data !== '0) begin
      testsFailed++;
      $display("[TB] FAIL mid_reset: got valid/busy/done/drop/sat %b index %0d data %h, required all 0",
               {out_valid, busy, done, drop_err, sat_err}, out_index, out_data);
    end
    startRun(1);
    driveBeat(2, 5, allLanes(4), allLanes(8), 1'b1);
    pushModelDump();
    drainDump(doneSeen, timedOut);
    testsRun++;
    if (timedOut || doneSeen !== 1 || expQ.size() !== 0) begin
      testsFailed++;
      $display("[TB] FAIL mid_rerun_done: got %0d pulses %0d beats left, required 1 and 0", doneSeen, expQ.size());
    end
  endtask

  initial begin
    testsRun      = 0;
    testsFailed   = 0;
    rst           = 1'b1;
    start         = 1'b0;
    num_frames    = '0;
    in_valid      = 1'b0;
    in_last       = 1'b0;
    in_col_1      = '0;
    in_col_2      = '0;
    in_index_col1 = '0;
    in_index_col2 = '0;
    out_ready     = 1'b0;
    modelClear();
    test_reset();
    test_three_frames();
    test_same_index();
    test_saturation();
    test_reset_mid_accum();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
